// File: rtl/mult_seq.sv
// Sequential radix-4 Booth 32x32 signed multiplier: 16 RUN cycles per product.
// Optional upper product word on result_hi when MULT_SEQ_RESULT_HI_EN is defined.
module mult_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic [31:0] result,
  output logic        overflow,
  output logic        ready,
  output logic        busy
`ifdef MULT_SEQ_RESULT_HI_EN
  ,
  output logic [31:0] result_hi
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state;
  logic [3:0]  count;
  logic [31:0] mcand;
  logic [33:0] acc;
  logic [31:0] mplier;
  logic        q_m1;

  logic [33:0] a_ext;
  logic [33:0] pp;
  logic [33:0] sum;
  logic [66:0] shifted;
  logic [63:0] prod;

  always_comb begin
    a_ext = {{2{mcand[31]}}, mcand};
    pp = '0;
    case ({mplier[1:0], q_m1})
      3'b001,
      3'b010:  pp = a_ext;
      3'b011:  pp = a_ext << 1;
      3'b100:  pp = -(a_ext << 1);
      3'b101,
      3'b110:  pp = -a_ext;
      default: pp = '0;
    endcase
    sum = acc + pp;
    shifted = $signed({sum, mplier, q_m1}) >>> 2;
    // after the last shift the 64-bit product sits just above q_m1
    prod = shifted[64:1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      result   <= '0;
      overflow <= 1'b0;
      ready    <= 1'b0;
      busy     <= 1'b0;
`ifdef MULT_SEQ_RESULT_HI_EN
      result_hi <= '0;
`endif
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE,
        DONE: begin
          if (start) begin
            mcand  <= multiplicand;
            acc    <= '0;
            mplier <= multiplier;
            q_m1   <= 1'b0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc    <= shifted[66:33];
          mplier <= shifted[32:1];
          q_m1   <= shifted[0];
          count  <= count + 4'd1;
          if (count == 4'd15) begin
            state    <= DONE;
            busy     <= 1'b0;
            ready    <= 1'b1;
            result   <= prod[31:0];
            overflow <= prod[63:32] != {32{prod[31]}};
`ifdef MULT_SEQ_RESULT_HI_EN
            result_hi <= prod[63:32];
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports are named clock and reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising clock edge.
REQ-004 start  input  1  request to begin a multiply; operands sampled in the same cycle.
REQ-005 multiplicand  input  32  signed two's-complement operand A.
REQ-006 multiplier  input  32  signed two's-complement operand B.
REQ-007 result  output  32  low 32 bits of signed product A*B.
REQ-008 overflow  output  1  product not representable as 32-bit signed.
REQ-009 ready  output  1  one-cycle pulse: result/overflow valid.
REQ-010 busy  output  1  high while an operation is in progress.

Function
REQ-011 The block SHALL implement radix-4 Booth multiplication.
- Each cycle it examines 3 multiplier bits: {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
REQ-012 The partial product SHALL be selected from the 3-bit group, using a 34-bit sign-extended multiplicand:
- 000 -> 0; 001 -> +A; 010 -> +A; 011 -> +2A
- 100 -> -2A; 101 -> -A; 110 -> -A; 111 -> 0
REQ-013 The product register SHALL be 67 bits: {acc[33:0], mplier[31:0], q_m1}.
- Each RUN cycle adds the partial product to acc.
- It then arithmetic-shifts the whole register right by 2.
REQ-014 A 4-bit iteration counter SHALL run 0..15; exactly 16 RUN cycles complete one multiply.
REQ-015 States SHALL be:
- IDLE: start -> RUN; otherwise stay.
- RUN: after counter=15 -> DONE; otherwise stay.
- DONE: start -> RUN; otherwise -> IDLE.
REQ-016 On accepted start, operands SHALL be captured into internal registers.
- Counter clears to 0.
- acc clears to 0, mplier loads B, q_m1 loads 0.
REQ-017 Latency: start accepted at edge N; ready SHALL be high during the cycle after edge N+16, for exactly one cycle.
REQ-018 busy SHALL be high in RUN only.
REQ-019 result SHALL equal product bits [31:0].
- It SHALL hold its value from the ready cycle until the next accepted start completes.
REQ-020 overflow SHALL be 1 iff product bits [63:32] are not all equal to product bit [31].
- It is held together with result.
REQ-021 start asserted in RUN SHALL be ignored; operands and progress are unaffected.
REQ-022 start asserted in the DONE cycle SHALL be accepted.
- ready still pulses for the finished operation.
- The new operation's ready arrives 17 cycles later.
REQ-023 Operand changes after capture SHALL NOT affect the result in progress.
REQ-024 Arithmetic SHALL be exact for all 2^64 operand pairs, including 0x80000000 operands.

Reset
REQ-025 On reset, the state SHALL go to IDLE and the counter SHALL clear to 0.
- Outputs clear: result=0, overflow=0, ready=0, busy=0.
REQ-026 Reset asserted mid-operation SHALL abort it with no ready pulse.
- Reset has priority over a simultaneous start.
REQ-027 The first start after reset deasserts SHALL be accepted normally.

Configuration
REQ-028 Macro MULT_SEQ_RESULT_HI_EN defined:
- The block SHALL add output port result_hi (32 bits) = product bits [63:32].
- result_hi has the same hold and reset rules as result.
REQ-029 Macro MULT_SEQ_RESULT_HI_EN undefined:
- The result_hi port and its register SHALL be absent.
- All other behaviour is identical.

Verification
REQ-030 Reset, then start with A=3, B=4: result=12, overflow=0; ready exactly 17 cycles after start edge; busy high for 16 cycles.
REQ-031 A=0xFFFFFFFF, B=0xFFFFFFFF: result=1, overflow=0. A=0xFFFFFFF9 (-7), B=6: result=0xFFFFFFD6, overflow=0.
REQ-032 A=0x7FFFFFFF, B=2: result=0xFFFFFFFE, overflow=1. A=0x80000000, B=0xFFFFFFFF: result=0x80000000, overflow=1. With macro defined: result_hi=0x00000000 in both cases.
REQ-033 A=5, B=7, with start pulsed again at cycle 8 using A=1, B=1: the second start is ignored; result=35 at cycle 17; a start in the DONE cycle yields result=1 17 cycles later.
REQ-034 Start A=9, B=9, then assert reset at cycle 10: no ready pulse; all outputs 0; a fresh start with A=2, B=0x40000000 gives result=0x80000000, overflow=1.
